// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_seq_pkg
// Brief    : Shared state encoding and PC constants for the fetch sequencer.
// Revision : 1.0
// ============================================================================
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } pc_seq_state_t;

  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET = 32'd8;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_next_sel.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_sel
// Brief    : Combinational next-PC select (sequential step or branch target).
// Revision : 1.0
// ============================================================================
module pc_next_sel
  import pc_seq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_br_taken,
  input  logic [31:0] i_br_target,
  output logic [31:0] o_next_pc
);

  // Both paths are forced to a word boundary; the step wraps modulo 2^32.
  always_comb begin
    o_next_pc = align_word(i_pc + PC_STEP);
    if (i_br_taken) begin
      o_next_pc = align_word(i_br_target);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pc_sequencer
// Brief    : Owns the PC, sequences instruction fetch and flags fetch timeouts.
// Revision : 1.0
// ============================================================================
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MAX_WAIT     = 8
) (
  input  logic        i_clk_w,
  input  logic        i_rst_n_w,
  input  logic        i_stall_w,
  input  logic        i_br_taken_w,
  input  logic [31:0] i_br_target_w,
  output logic        o_imem_req_w,
  output logic [31:0] o_imem_addr_w,
  input  logic        i_imem_ack_w,
  input  logic [31:0] i_imem_rdata_w,
  output logic [31:0] o_instr_w,
  output logic        o_instr_vld_w,
  output logic [31:0] o_pc_w,
  output logic [31:0] o_pc_plus8_w,
  output logic        o_fetch_fault_w
);

  localparam int c_wait_w = $clog2(MAX_WAIT + 1);
  localparam logic [c_wait_w-1:0] c_max_wait = c_wait_w'(MAX_WAIT);
  localparam logic [c_wait_w-1:0] c_one      = c_wait_w'(1);

  pc_seq_state_t       r_state;
  logic [31:0]         r_pc;
  logic [31:0]         r_instr;
  logic [c_wait_w-1:0] r_wait_cnt;
  logic [c_wait_w-1:0] w_wait_inc;
  logic [31:0]         w_next_pc;

  pc_next_sel u_next_sel (
    .i_pc        (r_pc),
    .i_br_taken  (i_br_taken_w),
    .i_br_target (i_br_target_w),
    .o_next_pc   (w_next_pc)
  );

  assign w_wait_inc = r_wait_cnt + c_one;

  always_ff @(posedge i_clk_w or negedge i_rst_n_w) begin
    if (!i_rst_n_w) begin
      r_state    <= BOOT;
      r_pc       <= RESET_VECTOR;
      r_instr    <= 32'd0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state <= FETCH;
        end
        FETCH: begin
          // An ack in the expiring cycle still completes the fetch.
          if (i_imem_ack_w) begin
            r_instr    <= i_imem_rdata_w;
            r_wait_cnt <= '0;
            r_state    <= ISSUE;
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == c_max_wait) begin
              r_state <= FAULT;
            end
          end
        end
        ISSUE: begin
          if (!i_stall_w) begin
            r_pc    <= w_next_pc;
            r_state <= FETCH;
          end
        end
        FAULT: begin
          r_state <= FAULT;
        end
      endcase
    end
  end

  assign o_imem_req_w    = (r_state == FETCH);
  assign o_instr_vld_w   = (r_state == ISSUE);
  assign o_fetch_fault_w = (r_state == FAULT);
  assign o_pc_w          = r_pc;
  assign o_imem_addr_w   = r_pc;
  assign o_pc_plus8_w    = r_pc + PC_READ_OFFSET;
  assign o_instr_w       = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Directed self-checking bench for pc_sequencer.
// Revision : 1.0
// ============================================================================
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_vld;
  logic [31:0] pc;
  logic [31:0] pc_plus8;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .MAX_WAIT     (8)
  ) dut (
    .i_clk_w         (clk),
    .i_rst_n_w       (rst_n),
    .i_stall_w       (stall),
    .i_br_taken_w    (br_taken),
    .i_br_target_w   (br_target),
    .o_imem_req_w    (imem_req),
    .o_imem_addr_w   (imem_addr),
    .i_imem_ack_w    (imem_ack),
    .i_imem_rdata_w  (imem_rdata),
    .o_instr_w       (instr),
    .o_instr_vld_w   (instr_vld),
    .o_pc_w          (pc),
    .o_pc_plus8_w    (pc_plus8),
    .o_fetch_fault_w (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    stall = 0; br_taken = 0; br_target = 0; imem_ack = 0; imem_rdata = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (pc !== 32'h0 || pc_plus8 !== 32'h8 || imem_req !== 1'b0 || instr_vld !== 1'b0 ||
        instr !== 32'h0 || fetch_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: pc=%h p8=%h req=%b vld=%b instr=%h fault=%b, want 0/8/0/0/0/0",
               pc, pc_plus8, imem_req, instr_vld, instr, fetch_fault);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL boot_no_req: req=%b want 0", imem_req);
    end
  endtask

  // Zero-wait memory: addresses 0,4,8,12 with valid on every other cycle.
  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || instr_vld !== 1'b0 || imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_fetch[%0d]: req=%b vld=%b addr=%h want 1/0/%h", i, imem_req,
                 instr_vld, imem_addr, 32'(4 * i));
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      imem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b0 || instr_vld !== 1'b1 || instr !== 32'hA000_0000 + 32'(i) ||
          pc_plus8 !== 32'(4 * i + 8)) begin
        errors++;
        $display("FAIL seq_issue[%0d]: req=%b vld=%b instr=%h p8=%h want 0/1/%h/%h", i, imem_req,
                 instr_vld, instr, pc_plus8, 32'hA000_0000 + 32'(i), 32'(4 * i + 8));
      end
    end
  endtask

  task automatic test_wait3();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'd16 || instr_vld !== 1'b0) begin
        errors++;
        $display("FAIL wait3_req[%0d]: req=%b addr=%h vld=%b want 1/10/0", i, imem_req,
                 imem_addr, instr_vld);
      end
      if (i == 3) begin
        imem_ack = 1'b1;
        imem_rdata = 32'hE3A0_0001;
      end
    end
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_vld !== 1'b1 || instr !== 32'hE3A0_0001) begin
      errors++;
      $display("FAIL wait3_issue: vld=%b instr=%h want 1/e3a00001", instr_vld, instr);
    end
  endtask

  // Stall with a taken branch and stray acks; nothing may move.
  task automatic test_stall();
    stall = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0500;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (pc !== 32'd16 || instr !== 32'hE3A0_0001 || instr_vld !== 1'b1 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: pc=%h instr=%h vld=%b req=%b want 10/e3a00001/1/0", i,
                 pc, instr, instr_vld, imem_req);
      end
    end
    stall = 1'b0; br_taken = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd20) begin
      errors++;
      $display("FAIL stall_release: req=%b addr=%h want 1/14", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; imem_rdata = 32'hEA00_0010;
    @(negedge clk);
    imem_ack = 1'b0;
    br_taken = 1'b1; br_target = 32'h0000_1003;
    @(negedge clk);
    br_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_1000 || pc !== 32'h0000_1000) begin
      errors++;
      $display("FAIL branch_target: req=%b addr=%h pc=%h want 1/00001000", imem_req, imem_addr, pc);
    end
  endtask

  task automatic test_wrap();
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
    @(negedge clk);
    imem_ack = 1'b0;
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    @(negedge clk);
    br_taken = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || pc_plus8 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_top: addr=%h p8=%h want fffffffc/00000004", imem_addr, pc_plus8);
    end
    imem_ack = 1'b1; imem_rdata = 32'h3333_4444;
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_vld !== 1'b1 || pc !== 32'hFFFF_FFFC || pc_plus8 !== 32'h0000_0004) begin
      errors++;
      $display("FAIL wrap_issue: vld=%b pc=%h p8=%h want 1/fffffffc/00000004", instr_vld, pc,
               pc_plus8);
    end
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || pc_plus8 !== 32'h8) begin
      errors++;
      $display("FAIL wrap_zero: req=%b addr=%h p8=%h want 1/0/8", imem_req, imem_addr, pc_plus8);
    end
  endtask

  // Currently observing FETCH cycle 1 at address 0 with no ack.
  task automatic test_fault();
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_wait[%0d]: req=%b fault=%b want 1/0", i, imem_req, fetch_fault);
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_ack = (i == 2);
      checks++;
      if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_vld !== 1'b0 || pc !== 32'h0) begin
        errors++;
        $display("FAIL fault_sticky[%0d]: fault=%b req=%b vld=%b pc=%h want 1/0/0/0", i,
                 fetch_fault, imem_req, instr_vld, pc);
      end
    end
    imem_ack = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (fetch_fault !== 1'b0 || imem_req !== 1'b0 || instr_vld !== 1'b0 || instr !== 32'h0 ||
        pc !== 32'h0 || pc_plus8 !== 32'h8) begin
      errors++;
      $display("FAIL async_reset: fault=%b req=%b vld=%b instr=%h pc=%h p8=%h want 0/0/0/0/0/8",
               fetch_fault, imem_req, instr_vld, instr, pc, pc_plus8);
    end
  endtask

  // Ack on the last allowed cycle must beat the timeout.
  task automatic test_ack_at_limit();
    apply_reset();
    @(negedge clk);
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1) begin
        errors++;
        $display("FAIL limit_req[%0d]: req=%b want 1", i, imem_req);
      end
      if (i == 8) begin
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
      end
    end
    @(negedge clk);
    imem_ack = 1'b0;
    checks++;
    if (instr_vld !== 1'b1 || fetch_fault !== 1'b0 || instr !== 32'h1234_5678) begin
      errors++;
      $display("FAIL limit_ack: vld=%b fault=%b instr=%h want 1/0/12345678", instr_vld,
               fetch_fault, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait3();
    test_stall();
    test_branch();
    test_wrap();
    test_fault();
    test_ack_at_limit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
